// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode map
// and ALU operation codes.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  // Low two opcode bits select the instruction; any higher bit set is illegal.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_LW  = 2'd1;
  localparam logic [1:0] OP_SW  = 2'd2;
  localparam logic [1:0] OP_BEQ = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_ctrl_decode.sv
// Combinational control decode: state + latched opcode (+ mem_ready in FETCH)
// to datapath strobes.
module ctrl_decode
  import multicycle_control_pkg::*;
#(
  parameter int unsigned OPW = 2
) (
  input  state_t           state,
  input  logic [OPW-1:0]   op_q,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUsrc,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [1:0]       ALUOp,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             illegal
);

  logic       legal;
  logic [1:0] op_lo;

  assign legal = (32'(op_q) < 32'd4);
  assign op_lo = op_q[1:0];

  // Moore-style decode of the control strobes; everything defaults low.
  always_comb begin
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUOp    = ALU_ADD;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    illegal  = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: illegal = !legal;
      EXEC: if (legal) begin
        case (op_lo)
          OP_ADD: ALUOp = ALU_FUNCT;
          OP_LW, OP_SW: ALUsrc = 1'b1;
          default: begin
            ALUOp  = ALU_SUB;
            Branch = 1'b1;
          end
        endcase
      end
      MEM: if (legal) begin
        MemRead  = (op_lo == OP_LW);
        MemWrite = (op_lo == OP_SW);
      end
      WB: if (legal) begin
        RegWrite = (op_lo == OP_ADD) || (op_lo == OP_LW);
        RegDst   = (op_lo == OP_ADD);
        MemtoReg = (op_lo == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: state register, latched opcode, retired counter,
// and next-state logic around the ctrl_decode strobe decoder.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned OPW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUsrc,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic [1:0]      ALUOp,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic            illegal,
  output logic [2:0]      state,
  output logic [CNTW-1:0] retired
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic           retire;
  logic           legal;
  logic [1:0]     op_lo;

  assign legal = (32'(op_q) < 32'd4);
  assign op_lo = op_q[1:0];
  assign state = state_q;

  // Next state and the "instruction completes this cycle" flag.
  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: state_d = legal ? EXEC : FETCH;
      EXEC: begin
        case (op_lo)
          OP_ADD:       state_d = WB;
          OP_LW, OP_SW: state_d = MEM;
          default: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (!mem_ready) begin
          state_d = MEM;
        end else if (op_lo == OP_LW) begin
          state_d = WB;
        end else begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // State register, opcode latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && mem_ready) op_q <= opcode;
      if (retire) retired <= retired + 1'b1;
    end
  end

  ctrl_decode #(.OPW(OPW)) u_decode (
    .state     (state_q),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .RegDst    (RegDst),
    .RegWrite  (RegWrite),
    .ALUsrc    (ALUsrc),
    .Branch    (Branch),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .ALUOp     (ALUOp),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .illegal   (illegal)
  );

endmodule
